// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity encoding (common
// to the transmitter), oversampling constants and the data-length decode.
package uart_pkg;

    localparam int OVERSAMPLE  = 16;
    localparam int SYNC_STAGES = 2;

    // Parity type encoding, identical on the transmit and receive paths
    localparam logic PARITY_ODD  = 1'b0;
    localparam logic PARITY_EVEN = 1'b1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Index of the last data bit for a data_bit_num code (00:5 .. 11:8 bits)
    function automatic logic [2:0] data_last_idx(input logic [1:0] num);
        return 3'd4 + {1'b0, num};
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input synchroniser for the asynchronous serial line. Every stage resets to
// 1 so the line reads as idle (mark) while and after reset. STAGES >= 2.
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw line into the chain, oldest sample at the top
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    // Chain flops, reset to the idle line level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            // NOTE: non-blocking so every stage takes the previous stage's old value.
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver. Counts the shared 16x rx_tick, samples mid-bit, delivers
// 5-8 data bits (LSB first) with optional parity and 1/2 stop bits through a
// valid/ack handshake, and flags parity, framing and overrun errors.
// Build option: define UART_RX_MAJORITY_VOTE_EN to decide each bit (and the
// start-bit check) by majority of the samples at ticks 6, 7 and 8.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = uart_pkg::OVERSAMPLE,
    parameter int SYNC_STAGES = uart_pkg::SYNC_STAGES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_tick,
    output logic       rx_enable,
    input  logic [1:0] data_bit_num_i,
    input  logic       parity_en_i,
    input  logic       parity_type_i,
    input  logic       stop_bit_num_i,
    input  logic       rx_data_ack_i,
    output logic [7:0] rx_data_o,
    output logic       rx_data_valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       overrun_err_o,
    output logic       rts_n,
    input  logic       rx
);

    localparam logic [3:0] MID_TICK = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] BIT_TICK = 4'(OVERSAMPLE - 1);

    logic rxs;
    logic bit_val;

    uart_rx_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (rx),
        .q_o     (rxs)
    );

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Start is confirmed one tick later so the vote window covers ticks 6,7,8;
    // every later decision then also lands on tick 8 of its bit.
    localparam logic [3:0] START_TICK = MID_TICK + 4'd1;

    logic [1:0] hist_q;
    logic [1:0] hist_d;

    // Keep the two most recent tick samples for the vote
    always_comb begin
        hist_d = hist_q;
        if (rx_tick) begin
            hist_d = {hist_q[0], rxs};
        end
    end

    // Vote history flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
    localparam logic [3:0] START_TICK = MID_TICK;

    assign bit_val = rxs;
`endif

    rx_state_e  state_q,         state_d;
    logic [3:0] tick_cnt_q,      tick_cnt_d;
    logic [2:0] data_cnt_q,      data_cnt_d;
    logic       stop_cnt_q,      stop_cnt_d;
    logic       armed_q,         armed_d;
    logic [1:0] cfg_bits_q,      cfg_bits_d;
    logic       cfg_par_en_q,    cfg_par_en_d;
    logic       cfg_par_type_q,  cfg_par_type_d;
    logic       cfg_stop2_q,     cfg_stop2_d;
    logic [7:0] shift_q,         shift_d;
    logic       par_acc_q,       par_acc_d;
    logic       frame_acc_q,     frame_acc_d;
    logic [7:0] rx_data_q,       rx_data_d;
    logic       valid_q,         valid_d;
    logic       par_err_q,       par_err_d;
    logic       frame_err_q,     frame_err_d;
    logic       overrun_q,       overrun_d;
    logic       rts_n_q,         rts_n_d;
    logic       rx_enable_q,     rx_enable_d;

    logic       complete;
    logic       frame_now;

    // Frame sequencing, handshake and error flags
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d        = state_q;
        tick_cnt_d     = tick_cnt_q;
        data_cnt_d     = data_cnt_q;
        stop_cnt_d     = stop_cnt_q;
        armed_d        = armed_q;
        cfg_bits_d     = cfg_bits_q;
        cfg_par_en_d   = cfg_par_en_q;
        cfg_par_type_d = cfg_par_type_q;
        cfg_stop2_d    = cfg_stop2_q;
        shift_d        = shift_q;
        par_acc_d      = par_acc_q;
        frame_acc_d    = frame_acc_q;
        rx_data_d      = rx_data_q;
        valid_d        = valid_q;
        par_err_d      = par_err_q;
        frame_err_d    = frame_err_q;
        overrun_d      = overrun_q;
        complete       = 1'b0;
        frame_now      = frame_acc_q | ~bit_val;

        unique case (state_q)
            RX_IDLE: begin
                tick_cnt_d = 4'd0;
                // A line that stayed low since the last frame must go high before re-arming
                armed_d = armed_q | rxs;
                if (armed_q && !rxs) begin
                    state_d        = RX_START;
                    armed_d        = 1'b0;
                    cfg_bits_d     = data_bit_num_i;
                    cfg_par_en_d   = parity_en_i;
                    cfg_par_type_d = parity_type_i;
                    cfg_stop2_d    = stop_bit_num_i;
                    shift_d        = 8'h00;
                    data_cnt_d     = 3'd0;
                    stop_cnt_d     = 1'b0;
                    par_acc_d      = 1'b0;
                    frame_acc_d    = 1'b0;
                end
            end

            RX_START: begin
                if (rx_tick) begin
                    if (tick_cnt_q == START_TICK) begin
                        tick_cnt_d = 4'd0;
                        state_d    = bit_val ? RX_IDLE : RX_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end

            RX_DATA: begin
                if (rx_tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == BIT_TICK) begin
                        shift_d[data_cnt_q] = bit_val;
                        if (data_cnt_q == data_last_idx(cfg_bits_q)) begin
                            state_d = cfg_par_en_q ? RX_PARITY : RX_STOP;
                        end else begin
                            data_cnt_d = data_cnt_q + 3'd1;
                        end
                    end
                end
            end

            RX_PARITY: begin
                if (rx_tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == BIT_TICK) begin
                        // Odd parity wants an odd count of ones over data plus parity bit
                        par_acc_d = ((^shift_q) ^ bit_val) != (cfg_par_type_q == PARITY_ODD);
                        state_d   = RX_STOP;
                    end
                end
            end

            RX_STOP: begin
                if (rx_tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == BIT_TICK) begin
                        frame_acc_d = frame_now;
                        if (stop_cnt_q == cfg_stop2_q) begin
                            // Remainder of the last stop bit is treated as idle time
                            complete = 1'b1;
                            state_d  = RX_IDLE;
                        end else begin
                            stop_cnt_d = 1'b1;
                        end
                    end
                end
            end

            default: state_d = RX_IDLE;
        endcase

        if (complete) begin
            if (!valid_q || rx_data_ack_i) begin
                rx_data_d   = shift_q;
                par_err_d   = par_acc_q;
                frame_err_d = frame_now;
                valid_d     = 1'b1;
                overrun_d   = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_data_ack_i && valid_q) begin
            valid_d     = 1'b0;
            par_err_d   = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end

        rts_n_d     = valid_q;
        rx_enable_d = (state_d != RX_IDLE);
    end

    // All receiver state; reset aborts any frame in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= RX_IDLE;
            tick_cnt_q     <= 4'd0;
            data_cnt_q     <= 3'd0;
            stop_cnt_q     <= 1'b0;
            armed_q        <= 1'b0;
            cfg_bits_q     <= 2'b00;
            cfg_par_en_q   <= 1'b0;
            cfg_par_type_q <= 1'b0;
            cfg_stop2_q    <= 1'b0;
            shift_q        <= 8'h00;
            par_acc_q      <= 1'b0;
            frame_acc_q    <= 1'b0;
            rx_data_q      <= 8'h00;
            valid_q        <= 1'b0;
            par_err_q      <= 1'b0;
            frame_err_q    <= 1'b0;
            overrun_q      <= 1'b0;
            rts_n_q        <= 1'b1;
            rx_enable_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            tick_cnt_q     <= tick_cnt_d;
            data_cnt_q     <= data_cnt_d;
            stop_cnt_q     <= stop_cnt_d;
            armed_q        <= armed_d;
            cfg_bits_q     <= cfg_bits_d;
            cfg_par_en_q   <= cfg_par_en_d;
            cfg_par_type_q <= cfg_par_type_d;
            cfg_stop2_q    <= cfg_stop2_d;
            shift_q        <= shift_d;
            par_acc_q      <= par_acc_d;
            frame_acc_q    <= frame_acc_d;
            rx_data_q      <= rx_data_d;
            valid_q        <= valid_d;
            par_err_q      <= par_err_d;
            frame_err_q    <= frame_err_d;
            overrun_q      <= overrun_d;
            rts_n_q        <= rts_n_d;
            rx_enable_q    <= rx_enable_d;
        end
    end

    assign rx_enable       = rx_enable_q;
    assign rx_data_o       = rx_data_q;
    assign rx_data_valid_o = valid_q;
    assign parity_err_o    = par_err_q;
    assign frame_err_o     = frame_err_q;
    assign overrun_err_o   = overrun_q;
    assign rts_n           = rts_n_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one rx_tick every 4 clocks, frames driven bit
// by bit for 16 ticks each, outputs sampled on the falling clock edge.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_tick = 1'b0;
    logic       rx = 1'b1;
    logic       ack = 1'b0;
    logic [1:0] nbits = 2'b11;
    logic       par_en = 1'b0;
    logic       par_type = 1'b0;
    logic       stop2 = 1'b0;

    logic       rx_enable;
    logic [7:0] rx_data;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun_err;
    logic       rts_n;

    int checks = 0;
    int failures = 0;
    bit seen_enable;

    uart_rx dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .rx_tick         (rx_tick),
        .rx_enable       (rx_enable),
        .data_bit_num_i  (nbits),
        .parity_en_i     (par_en),
        .parity_type_i   (par_type),
        .stop_bit_num_i  (stop2),
        .rx_data_ack_i   (ack),
        .rx_data_o       (rx_data),
        .rx_data_valid_o (valid),
        .parity_err_o    (parity_err),
        .frame_err_o     (frame_err),
        .overrun_err_o   (overrun_err),
        .rts_n           (rts_n),
        .rx              (rx)
    );

    always #5 clk = ~clk;

    // 16x tick: one pulse every fourth clock, changed away from the active edge
    initial begin : tick_gen
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            rx_tick = (div == 3);
            div = (div + 1) % 4;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clk);
            if (rx_tick) k++;
        end
    endtask

    task automatic drive_bit(input logic v, input int n_ticks);
        @(negedge clk);
        rx = v;
        wait_ticks(n_ticks);
    endtask

    task automatic send_bits(input logic [7:0] data, input int n);
        drive_bit(1'b0, 16);
        for (int i = 0; i < n; i++) drive_bit(data[i], 16);
    endtask

    task automatic send_8n1(input logic [7:0] data);
        send_bits(data, 8);
        drive_bit(1'b1, 16);
    endtask

    // Bounded wait for the byte to appear; an expired bound is a failed check
    task automatic wait_valid(input string tag, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (valid) break;
        end
        check(tag, valid, 1);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", valid, 0);
        check("rst_errs", {parity_err, frame_err, overrun_err}, 3'b000);
        check("rst_rts_n", rts_n, 1);
        check("rst_rx_enable", rx_enable, 0);
        reset_n = 1'b1;
        wait_ticks(20);
        check("idle_rts_n", rts_n, 0);

        // 8N1 0xA5, rts_n follows valid one cycle later, ack clears
        send_bits(8'hA5, 8);
        @(negedge clk);
        rx = 1'b1;
        wait_valid("a5_valid", 400);
        check("a5_rts_lag", rts_n, 0);
        @(negedge clk);
        check("a5_rts_n", rts_n, 1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_errs", {parity_err, frame_err, overrun_err}, 3'b000);
        wait_ticks(12);
        pulse_ack();
        check("a5_ack_valid", valid, 0);
        @(negedge clk);
        check("a5_ack_rts_n", rts_n, 0);

        // 5 bits, even parity, 2 stop, 0x13 with wrong parity bit 0; cfg changed mid-frame
        nbits = 2'b00; par_en = 1'b1; par_type = 1'b1; stop2 = 1'b1;
        wait_ticks(4);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        nbits = 2'b11; par_en = 1'b0; stop2 = 1'b0;
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        check("p5_not_after_stop1", valid, 0);
        wait_valid("p5_valid", 400);
        check("p5_data", rx_data, 8'h13);
        check("p5_parity_err", parity_err, 1);
        check("p5_frame_err", frame_err, 0);
        wait_ticks(12);
        pulse_ack();
        check("p5_ack_perr", parity_err, 0);

        // 8N1 0x3C with stop bit 0, then line held low: no new frame
        wait_ticks(4);
        send_bits(8'h3C, 8);
        @(negedge clk);
        rx = 1'b0;
        wait_valid("fe_valid", 400);
        check("fe_data", rx_data, 8'h3C);
        check("fe_frame_err", frame_err, 1);
        seen_enable = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (rx_enable) seen_enable = 1'b1;
        end
        check("fe_held_low_no_frame", seen_enable, 0);
        pulse_ack();
        check("fe_ack_ferr", frame_err, 0);
        drive_bit(1'b1, 16);

        // 4-tick low glitch on idle line
        drive_bit(1'b0, 4);
        check("gl_in_start", rx_enable, 1);
        drive_bit(1'b1, 12);
        @(negedge clk);
        check("gl_enable_drop", rx_enable, 0);
        check("gl_valid", valid, 0);

        // Two frames without ack: first byte kept, overrun flagged
        send_8n1(8'h11);
        send_8n1(8'h22);
        wait_ticks(4);
        check("ov_data", rx_data, 8'h11);
        check("ov_valid", valid, 1);
        check("ov_overrun", overrun_err, 1);
        pulse_ack();
        check("ov_ack_valid", valid, 0);
        check("ov_ack_overrun", overrun_err, 0);

        // Reset in the middle of the data bits, then a clean frame
        wait_ticks(4);
        send_bits(8'hFF, 3);
        check("rs_in_frame", rx_enable, 1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rs_rx_enable", rx_enable, 0);
        check("rs_data", rx_data, 8'h00);
        check("rs_valid_rts", {valid, rts_n}, 2'b01);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        wait_ticks(20);
        check("rs_no_partial", valid, 0);
        send_8n1(8'h5A);
        check("rs_5a_valid", valid, 1);
        check("rs_5a_data", rx_data, 8'h5A);
        check("rs_5a_errs", {parity_err, frame_err, overrun_err}, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
